// File: rtl/coherent_bus_arbiter_if.sv
// Bus bundle between the coherent arbiter and its cache controllers / memory.
// The "master" modport is the arbiter's view; "slave" is the cores' and memory's view.
interface coherent_bus_arbiter_if #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LINE_W    = 256
);
  localparam int unsigned SRC_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [NUM_CORES-1:0]        req_valid;
  logic [2*NUM_CORES-1:0]      req_cmd;
  logic [NUM_CORES*ADDR_W-1:0] req_addr;
  logic [NUM_CORES*LINE_W-1:0] req_wdata;
  logic [NUM_CORES-1:0]        req_ready;

  logic                        snoop_valid;
  logic [1:0]                  snoop_cmd;
  logic [ADDR_W-1:0]           snoop_addr;
  logic [SRC_W-1:0]            snoop_src;

  logic [NUM_CORES-1:0]        snp_resp_valid;
  logic [NUM_CORES-1:0]        snp_shared;
  logic [NUM_CORES-1:0]        snp_dirty;
  logic [NUM_CORES*LINE_W-1:0] snp_data;

  logic                        mem_read;
  logic                        mem_write;
  logic [ADDR_W-1:0]           mem_addr;
  logic [LINE_W-1:0]           mem_wdata;
  logic [LINE_W-1:0]           mem_rdata;
  logic                        mem_resp;

  logic [NUM_CORES-1:0]        resp_valid;
  logic [LINE_W-1:0]           resp_data;
  logic                        resp_shared;
  logic                        proto_err;

  modport master (
    input  req_valid, req_cmd, req_addr, req_wdata,
    input  snp_resp_valid, snp_shared, snp_dirty, snp_data,
    input  mem_rdata, mem_resp,
    output req_ready, snoop_valid, snoop_cmd, snoop_addr, snoop_src,
    output mem_read, mem_write, mem_addr, mem_wdata,
    output resp_valid, resp_data, resp_shared, proto_err
  );

  modport slave (
    output req_valid, req_cmd, req_addr, req_wdata,
    output snp_resp_valid, snp_shared, snp_dirty, snp_data,
    output mem_rdata, mem_resp,
    input  req_ready, snoop_valid, snoop_cmd, snoop_addr, snoop_src,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    input  resp_valid, resp_data, resp_shared, proto_err
  );
endinterface

// File: rtl/coherent_bus_arbiter.sv
// Snooping bus arbiter: round-robin grant, snoop broadcast/collect, optional
// dirty writeback or memory fill, then a one-cycle completion to the requester.
module coherent_bus_arbiter #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LINE_W    = 256
) (
  input logic                    clk,
  input logic                    rst,
  coherent_bus_arbiter_if.master bus
);
  localparam int unsigned SRC_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {BUS_RD = 2'd0, BUS_RDX = 2'd1, BUS_UPGR = 2'd2, BUS_WB = 2'd3} cmd_e;
  typedef enum logic [2:0] {IDLE, SNOOP, MEM_WB, MEM_RD, MEM_WR, RESP} state_e;

  state_e               state_q, state_d;
  logic [SRC_W-1:0]     rr_ptr_q;
  logic [SRC_W-1:0]     src_q;
  cmd_e                 cmd_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [LINE_W-1:0]    line_q;
  logic [NUM_CORES-1:0] pending_q;
  logic                 shared_q, dirty_q, err_q, resp_shared_q;
  logic [SRC_W-1:0]     dirty_id_q;

  logic                 grant_any;
  logic [SRC_W-1:0]     grant_id;
  cmd_e                 grant_cmd;
  logic [NUM_CORES-1:0] got, new_dirty, pending_left;
  logic                 any_new_dirty, multi_new_dirty, found_dirty;
  logic [SRC_W-1:0]     new_dirty_id;
  logic                 snoop_done, shared_all, dirty_all, take_data;
  int unsigned          idx;

  // Round-robin search starting at rr_ptr, plus snoop reply bookkeeping.
  always_comb begin
    grant_any    = 1'b0;
    grant_id     = '0;
    found_dirty  = 1'b0;
    new_dirty_id = '0;
    idx          = 0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      idx = i + 32'(rr_ptr_q);
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!grant_any && bus.req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = SRC_W'(idx);
      end
    end
    grant_cmd = cmd_e'(bus.req_cmd[32'(grant_id)*2 +: 2]);

    got             = bus.snp_resp_valid & pending_q;
    new_dirty       = got & bus.snp_dirty;
    pending_left    = pending_q & ~bus.snp_resp_valid;
    any_new_dirty   = |new_dirty;
    multi_new_dirty = (new_dirty & (new_dirty - NUM_CORES'(1))) != '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (!found_dirty && new_dirty[i]) begin
        found_dirty  = 1'b1;
        new_dirty_id = SRC_W'(i);
      end
    end
    shared_all = shared_q | (|(got & bus.snp_shared));
    dirty_all  = dirty_q | any_new_dirty;
    // Replies may arrive out of index order; keep the lowest-index dirty owner's line.
    take_data  = any_new_dirty && (!dirty_q || (new_dirty_id < dirty_id_q));
    snoop_done = (pending_left == '0);
  end

  always_comb begin
    state_d          = state_q;
    bus.req_ready    = '0;
    bus.snoop_valid  = 1'b0;
    bus.snoop_cmd    = '0;
    bus.snoop_addr   = '0;
    bus.snoop_src    = '0;
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    bus.resp_valid   = '0;
    bus.resp_data    = '0;
    bus.resp_shared  = 1'b0;
    bus.proto_err    = err_q;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            bus.req_ready[grant_id] = 1'b1;
            state_d = (grant_cmd == BUS_WB) ? MEM_WR : SNOOP;
          end
        end
        SNOOP: begin
          bus.snoop_valid = 1'b1;
          bus.snoop_cmd   = cmd_q;
          bus.snoop_addr  = addr_q;
          bus.snoop_src   = src_q;
          if (snoop_done) begin
            if (cmd_q == BUS_UPGR) state_d = RESP;
            else if (dirty_all)    state_d = MEM_WB;
            else                   state_d = MEM_RD;
          end
        end
        MEM_WB, MEM_WR: begin
          bus.mem_write = 1'b1;
          bus.mem_addr  = addr_q;
          bus.mem_wdata = line_q;
          if (bus.mem_resp) state_d = RESP;
        end
        MEM_RD: begin
          bus.mem_read = 1'b1;
          bus.mem_addr = addr_q;
          if (bus.mem_resp) state_d = RESP;
        end
        RESP: begin
          bus.resp_valid[src_q] = 1'b1;
          bus.resp_data         = line_q;
          bus.resp_shared       = resp_shared_q;
          state_d               = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      src_q         <= '0;
      cmd_q         <= BUS_RD;
      addr_q        <= '0;
      line_q        <= '0;
      pending_q     <= '0;
      shared_q      <= 1'b0;
      dirty_q       <= 1'b0;
      dirty_id_q    <= '0;
      err_q         <= 1'b0;
      resp_shared_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            src_q         <= grant_id;
            cmd_q         <= grant_cmd;
            addr_q        <= bus.req_addr[32'(grant_id)*ADDR_W +: ADDR_W];
            line_q        <= bus.req_wdata[32'(grant_id)*LINE_W +: LINE_W];
            rr_ptr_q      <= (32'(grant_id) == NUM_CORES - 1) ? '0 : SRC_W'(32'(grant_id) + 1);
            pending_q     <= ~(NUM_CORES'(1) << grant_id);
            shared_q      <= 1'b0;
            dirty_q       <= 1'b0;
            dirty_id_q    <= '0;
            resp_shared_q <= 1'b0;
          end
        end
        SNOOP: begin
          pending_q <= pending_left;
          shared_q  <= shared_all;
          dirty_q   <= dirty_all;
          if (take_data) begin
            dirty_id_q <= new_dirty_id;
            line_q     <= bus.snp_data[32'(new_dirty_id)*LINE_W +: LINE_W];
          end
          if (multi_new_dirty || (dirty_q && any_new_dirty)) err_q <= 1'b1;
          if (snoop_done) begin
            resp_shared_q <= (cmd_q == BUS_RD) && (shared_all || dirty_all);
            if (cmd_q == BUS_UPGR) line_q <= '0;
          end
        end
        MEM_RD: begin
          if (bus.mem_resp) line_q <= bus.mem_rdata;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_coherent_bus_arbiter.sv
// Randomized bench for coherent_bus_arbiter: the bench plays cores and memory and
// predicts each transaction's grant, memory traffic and completion from the protocol rules.
module tb_coherent_bus_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  coherent_bus_arbiter_if #(.NUM_CORES(N), .ADDR_W(AW), .LINE_W(LW)) bus ();

  coherent_bus_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .LINE_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int rr       = 0;
  bit exp_err  = 1'b0;

  logic [AW-1:0] addr_tab  [N];
  logic [LW-1:0] wdata_tab [N];
  logic [LW-1:0] sdata     [N];
  int            dly       [N];

  task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic clear_snoop();
    bus.snp_resp_valid = '0;
    bus.snp_shared     = '0;
    bus.snp_dirty      = '0;
  endtask

  task automatic randomize_tabs();
    for (int i = 0; i < N; i++) begin
      addr_tab[i]  = $urandom;
      wdata_tab[i] = rand_line();
      sdata[i]     = rand_line();
      dly[i]       = $urandom_range(0, 3);
    end
  endtask

  task automatic run_txn(input logic [N-1:0] vmask, input logic [2*N-1:0] cmds,
                         input logic [N-1:0] sh_m, input logic [N-1:0] dk_m,
                         input int mem_lat, input bit abort, input logic [LW-1:0] rdata);
    int id, dirty_id, last;
    logic [1:0]    c;
    logic [N-1:0]  onehot, s_m, d_m;
    logic [LW-1:0] exp_data, exp_wd;
    logic [AW-1:0] exp_addr;
    bit            exp_sh, do_mem, is_wr;

    id = -1;
    for (int i = 0; i < N; i++)
      if (id < 0 && vmask[(rr + i) % N]) id = (rr + i) % N;
    onehot = '0;
    onehot[id] = 1'b1;
    bus.req_valid = vmask;
    bus.req_cmd   = cmds;
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i*AW +: AW]  = addr_tab[i];
      bus.req_wdata[i*LW +: LW] = wdata_tab[i];
    end
    @(negedge clk);
    check_eq("req_ready", bus.req_ready, onehot);
    c  = cmds[id*2 +: 2];
    rr = (id + 1) % N;
    tick();
    bus.req_valid = '0;

    exp_sh   = 1'b0;
    exp_data = '0;
    do_mem   = 1'b1;
    is_wr    = 1'b1;
    exp_addr = addr_tab[id];
    exp_wd   = wdata_tab[id];

    if (c != 2'd3) begin
      s_m  = sh_m & ~onehot;
      d_m  = dk_m & ~onehot;
      last = 0;
      for (int i = 0; i < N; i++)
        if (i != id && dly[i] > last) last = dly[i];
      for (int k = 0; k <= last; k++) begin
        for (int i = 0; i < N; i++) begin
          bus.snp_resp_valid[i] = (i == id) ? (k == 0) : (dly[i] == k);
          bus.snp_shared[i] = bus.snp_resp_valid[i] ? sh_m[i] : 1'($urandom);
          bus.snp_dirty[i]  = (i == id) ? 1'b1 : (bus.snp_resp_valid[i] ? dk_m[i] : 1'($urandom));
          bus.snp_data[i*LW +: LW] = sdata[i];
        end
        bus.mem_resp  = (k == 0);
        bus.mem_rdata = rand_line();
        @(negedge clk);
        check_eq("snoop_valid", bus.snoop_valid, 1'b1);
        if (k == 0) begin
          check_eq("snoop_addr", bus.snoop_addr, exp_addr);
          check_eq("snoop_cmd", bus.snoop_cmd, c);
          check_eq("snoop_src", bus.snoop_src, id);
        end
        tick();
      end
      clear_snoop();
      bus.mem_resp = 1'b0;
      if ($countones(d_m) > 1) exp_err = 1'b1;
      dirty_id = -1;
      for (int i = 0; i < N; i++)
        if (dirty_id < 0 && d_m[i]) dirty_id = i;
      exp_sh = (c == 2'd0) && ((s_m | d_m) != '0);
      if (c == 2'd2) do_mem = 1'b0;
      else if (dirty_id >= 0) begin
        exp_data = sdata[dirty_id];
        exp_wd   = sdata[dirty_id];
      end else begin
        is_wr    = 1'b0;
        exp_data = rdata;
      end
    end

    if (do_mem) begin
      for (int k = 0; k <= mem_lat; k++) begin
        bus.mem_resp       = (k == mem_lat) && !abort;
        bus.mem_rdata      = (k == mem_lat) ? rdata : rand_line();
        bus.snp_resp_valid = N'($urandom);
        bus.snp_dirty      = '1;
        @(negedge clk);
        check_eq("mem_write", bus.mem_write, is_wr);
        check_eq("mem_read", bus.mem_read, !is_wr);
        check_eq("mem_addr", bus.mem_addr, exp_addr);
        if (is_wr) check_eq("mem_wdata", bus.mem_wdata, exp_wd);
        if (abort) begin
          tick();
          rst = 1'b1;
          clear_snoop();
          tick();
          rst = 1'b0;
          bus.mem_resp  = 1'b1;
          bus.mem_rdata = rdata;
          @(negedge clk);
          check_eq("abort_resp", bus.resp_valid, '0);
          check_eq("abort_mem_read", bus.mem_read, 1'b0);
          check_eq("abort_snoop", bus.snoop_valid, 1'b0);
          tick();
          bus.mem_resp = 1'b0;
          @(negedge clk);
          check_eq("abort_resp_late", bus.resp_valid, '0);
          tick();
          rr      = 0;
          exp_err = 1'b0;
          return;
        end
        tick();
      end
      bus.mem_resp = 1'b0;
      clear_snoop();
    end

    @(negedge clk);
    check_eq("resp_valid", bus.resp_valid, onehot);
    if (c != 2'd3) check_eq("resp_data", bus.resp_data, exp_data);
    check_eq("resp_shared", bus.resp_shared, exp_sh);
    check_eq("proto_err", bus.proto_err, exp_err);
    tick();
    @(negedge clk);
    check_eq("resp_pulse", bus.resp_valid, '0);
    check_eq("idle_snoop", bus.snoop_valid, 1'b0);
    tick();
  endtask

  initial begin
    logic [N-1:0] dk;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_cmd   = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.snp_data  = '0;
    bus.mem_rdata = '0;
    bus.mem_resp  = 1'b0;
    clear_snoop();
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_req_ready", bus.req_ready, '0);
    check_eq("rst_snoop_valid", bus.snoop_valid, 1'b0);
    check_eq("rst_mem_rw", {bus.mem_read, bus.mem_write}, '0);
    check_eq("rst_resp_valid", bus.resp_valid, '0);
    check_eq("rst_proto_err", bus.proto_err, 1'b0);
    tick();

    // Simultaneous BusRd from cores 0 and 2, then confirm the pointer lands on 3.
    randomize_tabs();
    run_txn(4'b0101, 8'h00, 4'h0, 4'h0, 1, 1'b0, rand_line());
    run_txn(4'b0100, 8'h00, 4'h0, 4'h0, 1, 1'b0, rand_line());
    run_txn(4'b1111, 8'h00, 4'h0, 4'h0, 0, 1'b0, rand_line());

    // Core 1 BusRd 0x40, no sharers, memory fill after 3 cycles.
    randomize_tabs();
    addr_tab[1] = 32'h40;
    run_txn(4'b0010, 8'h00, 4'h0, 4'h0, 3, 1'b0, {8{32'hAAAA_AAAA}});

    // Core 0 BusRdX 0x80 with core 3 holding the line dirty.
    randomize_tabs();
    addr_tab[0] = 32'h80;
    sdata[3]    = {8{32'h5555_5555}};
    run_txn(4'b0001, 8'h01, 4'h0, 4'b1000, 2, 1'b0, rand_line());

    // Core 2 BusUpgr with staggered replies.
    randomize_tabs();
    dly[0] = 0;
    dly[1] = 2;
    dly[3] = 1;
    run_txn(4'b0100, 8'h20, 4'hF, 4'h0, 0, 1'b0, rand_line());

    // Two dirty owners: sticky protocol error.
    randomize_tabs();
    run_txn(4'b0001, 8'h00, 4'h0, 4'b0110, 1, 1'b0, rand_line());
    randomize_tabs();
    run_txn(4'b0010, 8'h00, 4'h0, 4'h0, 0, 1'b0, rand_line());

    for (int t = 0; t < 40; t++) begin
      randomize_tabs();
      dk = '0;
      case ($urandom_range(0, 3))
        0: dk[$urandom_range(0, N - 1)] = 1'b1;
        1: dk = N'($urandom);
        default: ;
      endcase
      run_txn(N'($urandom_range(1, 15)), 8'($urandom), N'($urandom), dk,
              $urandom_range(0, 4), 1'b0, rand_line());
    end

    // Reset while a memory read is outstanding, then a late mem_resp.
    randomize_tabs();
    run_txn(4'b0010, 8'h00, 4'h0, 4'h0, 3, 1'b1, rand_line());
    randomize_tabs();
    run_txn(4'b1111, 8'h00, 4'h0, 4'h0, 1, 1'b0, rand_line());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
